// File: rtl/gravity_controller.sv
// gravity_controller: drop/spawn sequencer producing the 3-bit phase code used by the
// piece tracker and board logic. It runs the gravity timer, decides drop versus lock on
// each tick, waits for line clearing, spawns pieces and detects game over.
// Optional feature macro: SOFT_DROP_EN (keycode 8'h16 shortens the tick threshold in HOLD).
module gravity_controller #(
   parameter logic [23:0] GRAVITY_PERIOD  = 24'd5_000_000,
   parameter logic [23:0] PERIOD_STEP     = 24'd400_000,
   parameter logic [23:0] MIN_PERIOD      = 24'd500_000,
   parameter int unsigned LINES_PER_LEVEL = 10
) (
   input  logic       Clk,
   input  logic       reset,
   input  logic [7:0] keycode,
   input  logic       start,
   input  logic       block_can_drop,
   input  logic       spawn_blocked,
   input  logic       clear_done,
   input  logic [2:0] lines_cleared,
   output logic [2:0] state,
   output logic       lock_pulse,
   output logic [4:0] level,
   output logic       game_over
);

   // Encodings are the downstream phase codes; only StDrop and StSpawn move the piece.
   typedef enum logic [2:0] {
      StHold  = 3'b000,
      StDrop  = 3'b001,
      StSpawn = 3'b010,
      StLock  = 3'b011,
      StOver  = 3'b100,
      StIdle  = 3'b101
   } state_e;

   state_e      state_q;
   logic        lock_pulse_q;
   logic        game_over_q;
   logic [4:0]  level_q;
   logic [15:0] line_mod_q;   // lines cleared since the last level increment
   logic [23:0] gcnt_q;       // gravity counter
   logic [23:0] period_q;     // gravity period latched on HOLD entry

   logic signed [28:0] period_raw;
   logic [23:0]        period_next;
   logic [23:0]        tick_thr;
   logic               tick;
   logic [15:0]        line_sum;
   logic [15:0]        line_mod_next;
   logic               level_up;
   logic               restart;

   // Period for the current level, computed wide and signed so large levels cannot wrap.
   always_comb begin
      period_raw = $signed({5'd0, GRAVITY_PERIOD})
                 - $signed({24'd0, level_q}) * $signed({5'd0, PERIOD_STEP});
      if (period_raw < $signed({5'd0, MIN_PERIOD})) begin
         period_next = MIN_PERIOD;
      end else begin
         period_next = period_raw[23:0];
      end
   end

`ifdef SOFT_DROP_EN
   // Tick threshold: soft-drop key shortens it to period/8 (at least 1) while held.
   always_comb begin
      tick_thr = period_q;
      if (keycode == 8'h16) begin
         tick_thr = period_q >> 3;
         if (tick_thr == 24'd0) begin
            tick_thr = 24'd1;
         end
      end
   end
`else
   // Tick threshold: gravity period only; keycode has no influence on timing.
   always_comb begin
      tick_thr = period_q;
   end

   logic unused_keycode;
   assign unused_keycode = ^keycode;
`endif

   // Greater-or-equal so a shortened threshold below the current count fires at once.
   assign tick = (({1'b0, gcnt_q} + 25'd1) >= {1'b0, tick_thr});

   // Line accounting: a clear that reaches a multiple of LINES_PER_LEVEL bumps the level once.
   always_comb begin
      line_sum      = line_mod_q + {13'd0, lines_cleared};
      level_up      = ({16'd0, line_sum} >= LINES_PER_LEVEL);
      line_mod_next = 16'({16'd0, line_sum} % LINES_PER_LEVEL);
   end

   // Start restarts the game from every state except the single SPAWN cycle.
   assign restart = start && (state_q != StSpawn);

   // Phase sequencer with registered strobes, level and counters.
   always_ff @(posedge Clk) begin
      if (reset) begin
         state_q      <= StIdle;
         lock_pulse_q <= 1'b0;
         game_over_q  <= 1'b0;
         level_q      <= 5'd0;
         line_mod_q   <= 16'd0;
         gcnt_q       <= 24'd0;
         period_q     <= GRAVITY_PERIOD;
      end else if (restart) begin
         state_q      <= StSpawn;
         lock_pulse_q <= 1'b0;
         game_over_q  <= 1'b0;
         level_q      <= 5'd0;
         line_mod_q   <= 16'd0;
         gcnt_q       <= 24'd0;
      end else begin
         lock_pulse_q <= 1'b0;
         unique case (state_q)
            StIdle, StOver: begin
               // Waiting for start, handled above.
            end
            StSpawn: begin
               if (spawn_blocked) begin
                  state_q     <= StOver;
                  game_over_q <= 1'b1;
               end else begin
                  state_q  <= StHold;
                  gcnt_q   <= 24'd0;
                  period_q <= period_next;
               end
            end
            StHold: begin
               if (tick) begin
                  if (block_can_drop) begin
                     state_q <= StDrop;
                     gcnt_q  <= 24'd0;
                  end else begin
                     state_q      <= StLock;
                     lock_pulse_q <= 1'b1;
                  end
               end else begin
                  gcnt_q <= gcnt_q + 24'd1;
               end
            end
            StDrop: begin
               // The DROP cycle counts toward the next row so rows are one period apart.
               state_q  <= StHold;
               gcnt_q   <= gcnt_q + 24'd1;
               period_q <= period_next;
            end
            StLock: begin
               // A clear_done coinciding with the first LOCK cycle belongs to nothing.
               if (clear_done && !lock_pulse_q) begin
                  state_q    <= StSpawn;
                  line_mod_q <= line_mod_next;
                  if (level_up && (level_q != 5'd31)) begin
                     level_q <= level_q + 5'd1;
                  end
               end
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

   assign state      = state_q;
   assign lock_pulse = lock_pulse_q;
   assign level      = level_q;
   assign game_over  = game_over_q;

endmodule

// File: doc/gravity_controller.md
# gravity_controller

Drop/spawn sequencer that generates the 3-bit `state` code consumed by the piece center tracker and board logic. It is the producer side of that state interface. It runs the gravity timer, decides per tick whether the active piece falls one row or locks, waits for line clearing, spawns the next piece, and detects game over. It sits between the keyboard keycode path, the board collision checker, and every block that decodes `state`.

## Interface
Parameters:
- GRAVITY_PERIOD, 24'd5_000_000 — clocks per gravity tick at level 0
- PERIOD_STEP, 24'd400_000 — period reduction per level
- MIN_PERIOD, 24'd500_000 — floor on the gravity period
- LINES_PER_LEVEL, 10 — cleared lines needed per level increment

Ports:
- Clk  in  1  system clock
- reset  in  1  synchronous, active-high
- keycode  in  8  current keyboard keycode (8'h00 = none)
- start  in  1  one-cycle pulse that starts or restarts a game
- block_can_drop  in  1  active piece may move down one row
- spawn_blocked  in  1  spawn location is occupied
- clear_done  in  1  one-cycle pulse: board finished line clear after lock
- lines_cleared  in  3  lines removed; valid with clear_done (0–4)
- state  out  3  phase code: 000 HOLD, 001 DROP, 010 SPAWN, 011 LOCK, 100 OVER, 101 IDLE
- lock_pulse  out  1  one-cycle strobe when entering LOCK
- level  out  5  current level, saturates at 31
- game_over  out  1  high while in OVER

## Operation
- FSM states and encodings follow the `state` port. Only 001 and 010 alter piece position downstream. All other codes are neutral.
- IDLE: on `start` -> SPAWN. The same cycle clears `level`, the line count, and the gravity counter.
- SPAWN (exactly 1 cycle):
  - `spawn_blocked`=1 -> OVER.
  - Otherwise -> HOLD, with the gravity counter cleared.
- HOLD: the gravity counter increments each cycle. When counter == period−1 (tick):
  - `block_can_drop`=1 -> DROP.
  - `block_can_drop`=0 -> LOCK.
- DROP (exactly 1 cycle) -> HOLD. The counter is cleared on DROP entry.
- LOCK: `lock_pulse`=1 in the first LOCK cycle only. Wait for `clear_done` -> SPAWN.
  - `clear_done` arriving in the same cycle as LOCK entry is ignored.
  - Lines are added on `clear_done`. `level` increments each time the running line count crosses a multiple of LINES_PER_LEVEL, at most +1 per clear.
- OVER: hold until `start` -> SPAWN with full clear, same as from IDLE. `keycode` is ignored.
- `start` in HOLD, DROP, or LOCK restarts the game: full clear, -> SPAWN.
- Period = max(GRAVITY_PERIOD − level·PERIOD_STEP, MIN_PERIOD).
  - Computed in 29-bit signed arithmetic before clamping, so there is no wrap.
  - Registered. A level change takes effect on the next HOLD entry.

## Timing
- Reset values: `state`=101 (IDLE), `lock_pulse`=0, `level`=0, `game_over`=0, internal counters 0.
- All outputs are registered. No combinational input->output paths.
- Latency from a tick to DROP/LOCK: 1 clock. DROP is asserted for exactly 1 clock per row.
- `start` -> SPAWN: 1 clock. SPAWN -> HOLD/OVER: 1 clock.
- `clear_done` -> SPAWN: 1 clock. `lock_pulse` is high for 1 clock, coincident with the first `state`=011.
- Reset has priority over every input, in any state, including mid-LOCK. A pending `clear_done` after reset is ignored.

## Configuration
- SOFT_DROP_EN defined: while `keycode`==8'h16 in HOLD, the tick threshold becomes (period>>3), with a floor of 1.
  - If the counter already is ≥ the threshold, the tick fires on the next cycle.
  - Releasing the key restores the normal threshold without clearing the counter.
  - Each soft-dropped row follows the same DROP/LOCK rules.
- SOFT_DROP_EN undefined: `keycode` has no effect on timing. Only gravity moves the piece.

## Test plan
(GRAVITY_PERIOD=8, PERIOD_STEP=2, MIN_PERIOD=3, LINES_PER_LEVEL=10)
- Reset, then `start` -> `state` 101 ->010 ->000. With `block_can_drop`=1, `state`=001 for 1 cycle every 8 clocks. `level`=0.
- `block_can_drop`=0 at a tick -> `state`=011 and `lock_pulse`=1 for 1 cycle. `clear_done` 3 cycles later -> SPAWN next cycle -> HOLD.
- Three clears of `lines_cleared`=4 -> `level`=1 after the third. The next HOLD ticks every 6 clocks. At `level`≥3 the period holds at 3.
- `spawn_blocked`=1 during SPAWN -> `state`=100 and `game_over`=1. Ticks and keycodes are ignored. `start` -> SPAWN with `level`=0 and `game_over`=0.
- `reset` asserted mid-LOCK, with `clear_done` the following cycle -> `state`=101 and all outputs at reset values. No SPAWN occurs.
- SOFT_DROP_EN: hold `keycode`=8'h16 in HOLD -> DROP every 2 clocks (8>>3=1; counter clear + 1). Release -> back to 8-clock spacing. Without the macro -> 8-clock spacing throughout.
